fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from the upstream byte FIFO one at a time and
// serialises each onto an asynchronous 8N1 line, with an optional parity bit.
//
// Ports:
//   clock     in   sole clock, rising edge
//   reset     in   asynchronous active-high reset
//   enable    in   permits popping a new byte (sampled only while idle)
//   empty     in   FIFO empty flag
//   fifodata  in   FIFO read data, valid the cycle after read
//   read      out  FIFO read strobe (registered, one pulse per frame)
//   tx        out  serial line, idles high (registered)
//   busy      out  high whenever the block is not idle (registered)
//   sent      out  one-cycle pulse on the last cycle of the stop bit (registered)
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       empty,
    input  logic [7:0] fifodata,
    output logic       read,
    output logic       tx,
    output logic       busy,
    output logic       sent
);

    localparam int unsigned    CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             parity_q, parity_d;
    logic             read_q, read_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            read_q   <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            read_q   <= read_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            sent_q   <= sent_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        read_d   = 1'b0;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        sent_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable && !empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                // FIFO presents the byte on fifodata during the next cycle
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d  = fifodata;
                parity_d = (^fifodata) ^ PARITY_ODD;
                cnt_d    = CNT_RELOAD;
                state_d  = S_START;
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_RELOAD;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_RELOAD;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        read_d = (state_d == S_POP);
        busy_d = (state_d != S_IDLE);
        // Last stop-bit cycle is the one whose counter value is zero
        sent_d = (state_d == S_STOP) && (cnt_d == '0);
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign read = read_q;
    assign tx   = tx_q;
    assign busy = busy_q;
    assign sent = sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (4 clk/bit no parity, 4 clk/bit even
// parity, 2 clk/bit odd parity), each fed by a small 32-deep FIFO model.
module tb_fifo_uart_tx;

    localparam int TIMEOUT = 2000;

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [10:0] exp;
        int          nbits;
    } vec_t;

    logic       clock;
    logic       reset;
    logic [2:0] enable;
    logic [2:0] empty_w;
    logic [2:0] read_w;
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] sent_w;
    logic [7:0] fdata [3];

    logic [7:0] mem [3][32];
    logic [5:0] wr_ptr [3] = '{default: 6'd0};
    logic [5:0] rd_ptr [3] = '{default: 6'd0};
    int         rd_cnt [3] = '{default: 0};
    int         sent_cnt [3] = '{default: 0};
    int         rd_empty [3] = '{default: 0};
    int         cpb_of [3] = '{4, 4, 2};

    int total = 0;
    int bad   = 0;

    vec_t vecs [9];

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_a (
        .clock(clock), .reset(reset), .enable(enable[0]), .empty(empty_w[0]),
        .fifodata(fdata[0]), .read(read_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .sent(sent_w[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_b (
        .clock(clock), .reset(reset), .enable(enable[1]), .empty(empty_w[1]),
        .fifodata(fdata[1]), .read(read_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .sent(sent_w[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_c (
        .clock(clock), .reset(reset), .enable(enable[2]), .empty(empty_w[2]),
        .fifodata(fdata[2]), .read(read_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .sent(sent_w[2]));

    assign empty_w[0] = (wr_ptr[0] == rd_ptr[0]);
    assign empty_w[1] = (wr_ptr[1] == rd_ptr[1]);
    assign empty_w[2] = (wr_ptr[2] == rd_ptr[2]);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // FIFO read side plus read/sent bookkeeping
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (read_w[i]) begin
                fdata[i]  <= mem[i][rd_ptr[i][4:0]];
                rd_ptr[i] <= rd_ptr[i] + 6'd1;
                rd_cnt[i] <= rd_cnt[i] + 1;
                if (empty_w[i]) rd_empty[i] <= rd_empty[i] + 1;
            end
            if (sent_w[i]) sent_cnt[i] <= sent_cnt[i] + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int inst, input logic [7:0] d);
        int t;
        t = 0;
        while (6'(wr_ptr[inst] - rd_ptr[inst]) == 6'd32 && t < TIMEOUT) begin
            @(negedge clock);
            t++;
        end
        if (t >= TIMEOUT) chk("push_room", int'(6'(wr_ptr[inst] - rd_ptr[inst])), 31);
        mem[inst][wr_ptr[inst][4:0]] = d;
        wr_ptr[inst] = wr_ptr[inst] + 6'd1;
    endtask

    // Wait for a start bit, then check every cycle of the frame against exp
    task automatic capture(input int inst, input logic [10:0] exp, input int nbits,
                           input string tag, output int gap);
        int cpb, t, len, bit_bad, sent_bad, busy_bad;
        cpb = cpb_of[inst];
        len = nbits * cpb;
        t = 0; gap = 0; bit_bad = 0; sent_bad = 0; busy_bad = 0;
        @(negedge clock);
        while (tx_w[inst] !== 1'b0 && t < TIMEOUT) begin
            gap++;
            t++;
            @(negedge clock);
        end
        chk({tag, "_start"}, int'(tx_w[inst]), 0);
        if (tx_w[inst] !== 1'b0) return;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clock);
            if (tx_w[inst] !== exp[c / cpb]) bit_bad++;
            if (sent_w[inst] !== (c == len - 1)) sent_bad++;
            if (busy_w[inst] !== 1'b1) busy_bad++;
        end
        chk({tag, "_bits"}, bit_bad, 0);
        chk({tag, "_sent"}, sent_bad, 0);
        chk({tag, "_busy"}, busy_bad, 0);
    endtask

    function automatic logic [10:0] frame8n1(input logic [7:0] d);
        return {2'b01, d, 1'b0};
    endfunction

    initial begin
        int g, viol, r0, s0, t, i;

        // Expected frames, bit 0 = start bit, LSB-first data, [parity], stop
        vecs[0] = '{0, 8'hA5, 11'h34A, 10};
        vecs[1] = '{0, 8'h3C, 11'h278, 10};
        vecs[2] = '{1, 8'h07, 11'h60E, 11};
        vecs[3] = '{1, 8'hA5, 11'h54A, 11};
        vecs[4] = '{2, 8'h07, 11'h40E, 11};
        vecs[5] = '{2, 8'h00, 11'h600, 11};
        vecs[6] = '{2, 8'h80, 11'h500, 11};
        vecs[7] = '{0, 8'hFF, 11'h3FE, 10};
        vecs[8] = '{1, 8'h00, 11'h400, 11};

        // Reset with data available and enable high
        reset  = 1'b1;
        enable = 3'b111;
        push(0, 8'h96);
        viol = 0;
        repeat (4) begin
            @(negedge clock);
            if (tx_w[0] !== 1'b1 || read_w[0] !== 1'b0 || busy_w[0] !== 1'b0) viol++;
        end
        chk("reset_hold", viol, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("first_read", int'(read_w[0]), 1);
        capture(0, 11'h32C, 10, "rst_frame", g);
        @(negedge clock);
        chk("rst_reads", rd_cnt[0], 1);
        chk("rst_sent", sent_cnt[0], 1);
        chk("rst_busy_low", int'(busy_w[0]), 0);

        // Table of single-byte frames
        for (int v = 0; v < 9; v++) begin
            i  = vecs[v].inst;
            r0 = rd_cnt[i];
            s0 = sent_cnt[i];
            push(i, vecs[v].data);
            capture(i, vecs[v].exp, vecs[v].nbits, $sformatf("vec%0d", v), g);
            @(negedge clock);
            chk($sformatf("vec%0d_reads", v), rd_cnt[i] - r0, 1);
            chk($sformatf("vec%0d_sentcnt", v), sent_cnt[i] - s0, 1);
            chk($sformatf("vec%0d_busy_low", v), int'(busy_w[i]), 0);
            chk($sformatf("vec%0d_empty", v), int'(empty_w[i]), 1);
        end

        // Back-to-back frames
        r0 = rd_cnt[0];
        push(0, 8'h00);
        push(0, 8'hFF);
        capture(0, 11'h200, 10, "b2b0", g);
        capture(0, 11'h3FE, 10, "b2b1", g);
        chk("b2b_gap", g, 3);
        @(negedge clock);
        chk("b2b_reads", rd_cnt[0] - r0, 2);

        // Enable dropped mid-frame with three bytes queued
        r0 = rd_cnt[0];
        s0 = sent_cnt[0];
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        fork
            begin
                repeat (10) @(negedge clock);
                enable[0] = 1'b0;
            end
        join_none
        capture(0, 11'h222, 10, "en0", g);
        viol = 0;
        repeat (30) begin
            @(negedge clock);
            if (tx_w[0] !== 1'b1 || read_w[0] !== 1'b0 || busy_w[0] !== 1'b0) viol++;
        end
        chk("en_hold", viol, 0);
        chk("en_reads_held", rd_cnt[0] - r0, 1);
        enable[0] = 1'b1;
        capture(0, 11'h244, 10, "en1", g);
        capture(0, 11'h266, 10, "en2", g);
        chk("en_gap", g, 3);
        @(negedge clock);
        chk("en_reads", rd_cnt[0] - r0, 3);
        chk("en_sentcnt", sent_cnt[0] - s0, 3);

        // Reset during data bit 3
        r0 = rd_cnt[0];
        s0 = sent_cnt[0];
        push(0, 8'h37);
        push(0, 8'hC3);
        t = 0;
        @(negedge clock);
        while (tx_w[0] !== 1'b0 && t < TIMEOUT) begin
            t++;
            @(negedge clock);
        end
        chk("mid_start", int'(tx_w[0]), 0);
        repeat (17) @(negedge clock);
        chk("mid_bit3", int'(tx_w[0]), 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", int'(tx_w[0]), 1);
        chk("mid_rst_busy", int'(busy_w[0]), 0);
        viol = 0;
        repeat (3) begin
            @(negedge clock);
            if (read_w[0] !== 1'b0 || tx_w[0] !== 1'b1) viol++;
        end
        chk("mid_rst_hold", viol, 0);
        reset = 1'b0;
        capture(0, 11'h386, 10, "after_rst", g);
        @(negedge clock);
        chk("mid_reads", rd_cnt[0] - r0, 2);
        chk("mid_sentcnt", sent_cnt[0] - s0, 1);
        chk("mid_empty", int'(empty_w[0]), 1);

        // 33-byte drain across the FIFO pointer wrap
        r0 = rd_cnt[0];
        fork
            begin
                for (int k = 0; k < 33; k++) push(0, 8'(k * 37 + 5));
            end
        join_none
        for (int k = 0; k < 33; k++) begin
            capture(0, frame8n1(8'(k * 37 + 5)), 10, $sformatf("drain%0d", k), g);
        end
        @(negedge clock);
        chk("drain_reads", rd_cnt[0] - r0, 33);
        chk("drain_empty", int'(empty_w[0]), 1);

        chk("read_while_empty", rd_empty[0] + rd_empty[1] + rd_empty[2], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
